// File: rtl/mdu_iter.sv
// mdu_iter: iterative RV32M multiply/divide unit, one result bit per clock.
// Latency: accept edge E0 plus 32 iteration edges; done is high in the cycle after E32 and is sampled high at E33.
//          With MDU_EARLY_OUT_EN defined, divide by zero and signed overflow go straight to DONE (done sampled at E1).
// Backpressure: start is taken only when busy=0 (IDLE or DONE); a start while busy is dropped, never queued.
//
// Ports:
//   clk, rst        single clock, synchronous active-low reset
//   start           request an operation; accepted only when busy=0 and flush=0
//   funct3, A, B    RV32M opcode and operands, captured on the accepting edge
//   rd_in           destination tag, captured with the operation
//   flush           abort any in-flight operation; wins over a same-cycle start
//   busy            high exactly while iterating
//   done            single-cycle pulse, result/rd_out valid
//   result, rd_out  held from one done until the next done
//
// Optional feature macro: MDU_EARLY_OUT_EN (divide-by-zero and signed-overflow early out).
// Results are bit-identical with and without the macro; only latency differs.

module mdu_iter #(
    parameter int XLEN = 32
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            start,
    input  logic [2:0]      funct3,
    input  logic [XLEN-1:0] A,
    input  logic [XLEN-1:0] B,
    input  logic [4:0]      rd_in,
    input  logic            flush,
    output logic            busy,
    output logic            done,
    output logic [XLEN-1:0] result,
    output logic [4:0]      rd_out
);

    localparam int              CW       = $clog2(XLEN);
    localparam logic [CW-1:0]   CNT_LAST = CW'(XLEN - 1);
    localparam logic [XLEN-1:0] INT_MIN  = {1'b1, {(XLEN-1){1'b0}}};

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_CALC = 2'd1,
        S_DONE = 2'd2
    } state_e;

    state_e state_q, state_d;

    // ------------------------------------------------------------------
    // Operand decode (combinational, from the live inputs)
    // ------------------------------------------------------------------
    logic            op_div;
    logic            a_sgn, b_sgn;
    logic            a_neg, b_neg;
    logic            b_zero;
    logic            hi_sel;
    logic            neg_main;
    logic [XLEN-1:0] a_mag, b_mag;
    logic            accept;
    logic            early;
    logic [XLEN-1:0] early_res;

    always_comb begin
        op_div   = funct3[2];
        // MULH/MULHSU treat A as signed; MULH alone treats B as signed.
        // DIV/REM are signed, DIVU/REMU unsigned (funct3[0] set).
        a_sgn    = op_div ? ~funct3[0] : (funct3[1] ^ funct3[0]);
        b_sgn    = op_div ? ~funct3[0] : (funct3[1:0] == 2'b01);
        a_neg    = a_sgn & A[XLEN-1];
        b_neg    = b_sgn & B[XLEN-1];
        a_mag    = a_neg ? -A : A;
        b_mag    = b_neg ? -B : B;
        b_zero   = (B == '0);
        // Upper product half for MULH*, remainder for REM*.
        hi_sel   = op_div ? funct3[1] : (funct3[1:0] != 2'b00);
        // Divide by zero must return an all-ones quotient regardless of
        // operand signs, so the quotient is never negated in that case.
        neg_main = (a_neg ^ b_neg) & ~(op_div & b_zero);
    end

`ifdef MDU_EARLY_OUT_EN
    logic ovf;
    assign ovf       = ~funct3[0] & (A == INT_MIN) & (B == '1);
    assign early     = op_div & (b_zero | ovf);
    // Same values the iterative path would produce for these operands.
    assign early_res = funct3[1] ? (b_zero ? A : '0)
                                 : (b_zero ? '1 : INT_MIN);
`else
    assign early     = 1'b0;
    assign early_res = '0;
`endif

    assign accept = start & ~flush & ((state_q == S_IDLE) | (state_q == S_DONE));

    // ------------------------------------------------------------------
    // Iteration registers
    //   multiply: hi_q = partial product upper half, lo_q = multiplier
    //             shifting out / product lower half shifting in,
    //             opb_q = multiplicand magnitude
    //   divide:   hi_q = partial remainder, lo_q = dividend shifting out /
    //             quotient shifting in, opb_q = divisor magnitude
    // ------------------------------------------------------------------
    logic [XLEN-1:0] hi_q, hi_d;
    logic [XLEN-1:0] lo_q, lo_d;
    logic [XLEN-1:0] opb_q, opb_d;
    logic [CW-1:0]   cnt_q, cnt_d;
    logic            div_q, div_d;
    logic            hsel_q, hsel_d;
    logic            neg_q, neg_d;
    logic            rneg_q, rneg_d;
    logic [4:0]      tag_q, tag_d;
    logic [XLEN-1:0] result_q, result_d;
    logic [4:0]      rd_out_q, rd_out_d;

    // One shift-add or restoring-subtract step.
    logic [XLEN:0]   mul_sum;
    logic [XLEN:0]   rem_sh;
    logic [XLEN:0]   diff;
    logic            div_ge;
    logic [XLEN-1:0] it_hi, it_lo;

    always_comb begin
        mul_sum = {1'b0, hi_q} + (lo_q[0] ? {1'b0, opb_q} : '0);
        rem_sh  = {hi_q, lo_q[XLEN-1]};
        // The remainder stays below the divisor, so the shifted remainder
        // fits XLEN+1 bits and the top bit of the difference is its sign.
        diff    = rem_sh - {1'b0, opb_q};
        div_ge  = ~diff[XLEN];
        if (div_q) begin
            it_hi = div_ge ? diff[XLEN-1:0] : rem_sh[XLEN-1:0];
            it_lo = {lo_q[XLEN-2:0], div_ge};
        end else begin
            it_hi = mul_sum[XLEN:1];
            it_lo = {mul_sum[0], lo_q[XLEN-1:1]};
        end
    end

    // Sign fix-up applied to the values produced by the final iteration.
    logic [2*XLEN-1:0] prod, prod_s;
    logic [XLEN-1:0]   quo_s, rem_s, fin_res;

    always_comb begin
        prod   = {it_hi, it_lo};
        prod_s = neg_q ? -prod : prod;
        quo_s  = neg_q ? -it_lo : it_lo;
        rem_s  = rneg_q ? -it_hi : it_hi;
        if (div_q) begin
            fin_res = hsel_q ? rem_s : quo_s;
        end else begin
            fin_res = hsel_q ? prod_s[2*XLEN-1:XLEN] : prod_s[XLEN-1:0];
        end
    end

    // ------------------------------------------------------------------
    // FSM: state register
    // ------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (!rst) begin
            state_q <= S_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // FSM: next state
    always_comb begin
        state_d = state_q;
        case (state_q)
            S_IDLE: begin
                if (accept) begin
                    state_d = early ? S_DONE : S_CALC;
                end
            end
            S_CALC: begin
                if (cnt_q == CNT_LAST) begin
                    state_d = S_DONE;
                end
            end
            S_DONE: begin
                if (accept) begin
                    state_d = early ? S_DONE : S_CALC;
                end else begin
                    state_d = S_IDLE;
                end
            end
            default: state_d = S_IDLE;
        endcase
        if (flush) begin
            state_d = S_IDLE;
        end
    end

    // FSM: outputs
    always_comb begin
        busy = (state_q == S_CALC);
        done = (state_q == S_DONE);
    end

    assign result = result_q;
    assign rd_out = rd_out_q;

    // ------------------------------------------------------------------
    // Datapath next state
    // ------------------------------------------------------------------
    always_comb begin
        hi_d     = hi_q;
        lo_d     = lo_q;
        opb_d    = opb_q;
        cnt_d    = cnt_q;
        div_d    = div_q;
        hsel_d   = hsel_q;
        neg_d    = neg_q;
        rneg_d   = rneg_q;
        tag_d    = tag_q;
        result_d = result_q;
        rd_out_d = rd_out_q;

        if (accept) begin
            hi_d   = '0;
            lo_d   = op_div ? a_mag : b_mag;
            opb_d  = op_div ? b_mag : a_mag;
            cnt_d  = '0;
            div_d  = op_div;
            hsel_d = hi_sel;
            neg_d  = neg_main;
            rneg_d = a_neg;
            tag_d  = rd_in;
            if (early) begin
                result_d = early_res;
                rd_out_d = rd_in;
            end
        end else if ((state_q == S_CALC) && !flush) begin
            hi_d  = it_hi;
            lo_d  = it_lo;
            cnt_d = cnt_q + CW'(1);
            // Results only move on a completing iteration, so a flushed
            // operation leaves the previous result visible.
            if (cnt_q == CNT_LAST) begin
                result_d = fin_res;
                rd_out_d = tag_q;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            hi_q     <= '0;
            lo_q     <= '0;
            opb_q    <= '0;
            cnt_q    <= '0;
            div_q    <= 1'b0;
            hsel_q   <= 1'b0;
            neg_q    <= 1'b0;
            rneg_q   <= 1'b0;
            tag_q    <= '0;
            result_q <= '0;
            rd_out_q <= '0;
        end else begin
            hi_q     <= hi_d;
            lo_q     <= lo_d;
            opb_q    <= opb_d;
            cnt_q    <= cnt_d;
            div_q    <= div_d;
            hsel_q   <= hsel_d;
            neg_q    <= neg_d;
            rneg_q   <= rneg_d;
            tag_q    <= tag_d;
            result_q <= result_d;
            rd_out_q <= rd_out_d;
        end
    end

endmodule

// File: tb/tb_mdu_iter.sv
// tb_mdu_iter: table-driven vectors plus hand sequences for flush, reset,
// ignored starts and back-to-back issue. Expected results are queued when an
// operation is driven and compared when done is observed.

module tb_mdu_iter;

`ifdef MDU_EARLY_OUT_EN
    localparam int EO_LAT = 1;
`else
    localparam int EO_LAT = 33;
`endif

    logic        clk = 1'b0;
    logic        rst;
    logic        start;
    logic [2:0]  funct3;
    logic [31:0] A, B;
    logic [4:0]  rd_in;
    logic        flush;
    logic        busy, done;
    logic [31:0] result;
    logic [4:0]  rd_out;

    always #5 clk = ~clk;

    mdu_iter #(.XLEN(32)) dut (
        .clk    (clk),
        .rst    (rst),
        .start  (start),
        .funct3 (funct3),
        .A      (A),
        .B      (B),
        .rd_in  (rd_in),
        .flush  (flush),
        .busy   (busy),
        .done   (done),
        .result (result),
        .rd_out (rd_out)
    );

    typedef struct {
        logic [2:0]  f;
        logic [31:0] a;
        logic [31:0] b;
        logic [4:0]  rd;
        logic [31:0] res;
        bit          eo;
    } vec_t;

    typedef struct {
        logic [31:0] res;
        logic [4:0]  rd;
        int          t0;
        int          lat;
    } exp_t;

    exp_t sb[$];
    vec_t vt[25];
    int   checks = 0;
    int   passes = 0;
    int   cyc    = 0;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act === exp) passes++;
        else $display("FAIL %s: got 0x%08h, expected 0x%08h", name, act, exp);
    endtask

    task automatic timeout_fail(input string name);
        checks++;
        $display("FAIL %s: done not seen within 60 cycles, expected a done pulse", name);
        sb.delete();
    endtask

    // Scoreboard monitor: every done must match the oldest outstanding op.
    always @(negedge clk) begin
        exp_t e;
        if (done) begin
            if (sb.size() == 0) begin
                checks++;
                $display("FAIL unexpected_done: done=1 with rd_out=%0d, expected no done", rd_out);
            end else begin
                e = sb.pop_front();
                chk("result", result, e.res);
                chk("rd_out", 32'(rd_out), 32'(e.rd));
                chk("latency", cyc - e.t0, e.lat);
                chk("busy_in_done", 32'(busy), 32'd0);
            end
        end
    end

    // Called at a negedge: present an operation and queue its expectation.
    task automatic drive(input vec_t v);
        funct3 = v.f;
        A      = v.a;
        B      = v.b;
        rd_in  = v.rd;
        start  = 1'b1;
        sb.push_back('{v.res, v.rd, cyc, (v.eo ? EO_LAT : 33)});
    endtask

    // Issue one op, scramble the inputs afterwards, wait for done and check
    // how many cycles busy was high. Returns at the done negedge.
    task automatic run_op(input vec_t v);
        int  nbusy;
        bit  seen;
        drive(v);
        @(negedge clk);
        start  = 1'b0;
        A      = $urandom;
        B      = $urandom;
        funct3 = 3'($urandom);
        rd_in  = 5'($urandom);
        nbusy  = 0;
        seen   = 1'b0;
        for (int i = 0; i < 60 && !seen; i++) begin
            if (done) seen = 1'b1;
            else begin
                if (busy) nbusy++;
                @(negedge clk);
            end
        end
        if (!seen) timeout_fail("run_op_timeout");
        else chk("busy_cycles", nbusy, ((v.eo && EO_LAT == 1) ? 0 : 32));
    endtask

    task automatic no_done(input string name, input int n);
        int cnt;
        cnt = 0;
        repeat (n) begin
            @(negedge clk);
            if (done) cnt++;
        end
        chk(name, cnt, 0);
    endtask

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation time limit reached, expected completion");
        $fatal(1);
    end

    initial begin
        vec_t v;
        bit   seen;
        int   nb;

        vt[0]  = '{3'b000, 32'h00000007, 32'hFFFFFFFD, 5'd5,  32'hFFFFFFEB, 1'b0};
        vt[1]  = '{3'b001, 32'h80000000, 32'h80000000, 5'd1,  32'h40000000, 1'b0};
        vt[2]  = '{3'b011, 32'hFFFFFFFF, 32'hFFFFFFFF, 5'd2,  32'hFFFFFFFE, 1'b0};
        vt[3]  = '{3'b010, 32'hFFFFFFFF, 32'h00000002, 5'd3,  32'hFFFFFFFF, 1'b0};
        vt[4]  = '{3'b010, 32'h00000002, 32'hFFFFFFFF, 5'd4,  32'h00000001, 1'b0};
        vt[5]  = '{3'b000, 32'hFFFFFFFF, 32'hFFFFFFFF, 5'd6,  32'h00000001, 1'b0};
        vt[6]  = '{3'b001, 32'h12345678, 32'h00000010, 5'd7,  32'h00000001, 1'b0};
        vt[7]  = '{3'b011, 32'h80000000, 32'h00000004, 5'd8,  32'h00000002, 1'b0};
        vt[8]  = '{3'b001, 32'hFFFFFFFE, 32'h00000003, 5'd9,  32'hFFFFFFFF, 1'b0};
        vt[9]  = '{3'b000, 32'h00000000, 32'h00012345, 5'd0,  32'h00000000, 1'b0};
        vt[10] = '{3'b100, 32'hFFFFFFF9, 32'h00000002, 5'd10, 32'hFFFFFFFD, 1'b0};
        vt[11] = '{3'b110, 32'hFFFFFFF9, 32'h00000002, 5'd11, 32'hFFFFFFFF, 1'b0};
        vt[12] = '{3'b101, 32'h00001234, 32'h00000000, 5'd12, 32'hFFFFFFFF, 1'b1};
        vt[13] = '{3'b111, 32'h00001234, 32'h00000000, 5'd13, 32'h00001234, 1'b1};
        vt[14] = '{3'b100, 32'h80000000, 32'hFFFFFFFF, 5'd14, 32'h80000000, 1'b1};
        vt[15] = '{3'b110, 32'h80000000, 32'hFFFFFFFF, 5'd15, 32'h00000000, 1'b1};
        vt[16] = '{3'b100, 32'h00000064, 32'h00000000, 5'd16, 32'hFFFFFFFF, 1'b1};
        vt[17] = '{3'b110, 32'hFFFFFFFB, 32'h00000000, 5'd17, 32'hFFFFFFFB, 1'b1};
        vt[18] = '{3'b101, 32'hFFFFFFF9, 32'h00000002, 5'd18, 32'h7FFFFFFC, 1'b0};
        vt[19] = '{3'b111, 32'hFFFFFFF9, 32'h00000002, 5'd19, 32'h00000001, 1'b0};
        vt[20] = '{3'b100, 32'h00000007, 32'hFFFFFFFE, 5'd20, 32'hFFFFFFFD, 1'b0};
        vt[21] = '{3'b110, 32'h00000007, 32'hFFFFFFFE, 5'd21, 32'h00000001, 1'b0};
        vt[22] = '{3'b100, 32'h80000000, 32'h00000002, 5'd22, 32'hC0000000, 1'b0};
        vt[23] = '{3'b101, 32'h80000000, 32'hFFFFFFFF, 5'd23, 32'h00000000, 1'b0};
        vt[24] = '{3'b111, 32'h80000000, 32'hFFFFFFFF, 5'd24, 32'h80000000, 1'b0};

        rst = 1'b0; start = 1'b0; flush = 1'b0;
        funct3 = '0; A = '0; B = '0; rd_in = '0;
        repeat (3) @(negedge clk);
        chk("reset_busy",   32'(busy),   32'd0);
        chk("reset_done",   32'(done),   32'd0);
        chk("reset_result", result,      32'd0);
        chk("reset_rd_out", 32'(rd_out), 32'd0);
        rst = 1'b1;
        @(negedge clk);

        // Table; ops without a gap start in the previous op's done cycle.
        for (int i = 0; i < 25; i++) begin
            run_op(vt[i]);
            if (i % 3 == 2) repeat (2) @(negedge clk);
        end
        repeat (2) @(negedge clk);

        // Starts during CALC with other operands must be ignored.
        v = '{3'b000, 32'h00001234, 32'h00000010, 5'd9, 32'h00012340, 1'b0};
        drive(v);
        @(negedge clk);
        start = 1'b0;
        seen  = 1'b0;
        for (int i = 1; i <= 60 && !seen; i++) begin
            if (done) seen = 1'b1;
            else begin
                if (i == 3 || i == 4 || i == 20) begin
                    start = 1'b1; funct3 = 3'b100; A = $urandom; B = 32'h3; rd_in = 5'd30;
                end else start = 1'b0;
                @(negedge clk);
            end
        end
        start = 1'b0;
        if (!seen) timeout_fail("ignored_start_timeout");
        no_done("no_extra_done_after_ignored_start", 40);

        // Flush on the 10th CALC cycle.
        v = '{3'b000, 32'h00000003, 32'h00000005, 5'd4, 32'h0000000F, 1'b0};
        drive(v);
        @(negedge clk);
        start = 1'b0;
        nb = 0;
        for (int i = 0; i < 40 && nb < 10; i++) begin
            if (busy) nb++;
            if (nb < 10) @(negedge clk);
        end
        flush = 1'b1;
        @(negedge clk);
        flush = 1'b0;
        sb.delete();
        chk("flush_busy", 32'(busy), 32'd0);
        chk("flush_done", 32'(done), 32'd0);
        no_done("no_done_after_flush", 40);
        run_op(vt[0]);
        repeat (2) @(negedge clk);

        // Reset mid-CALC, with start held high while reset is asserted.
        drive(vt[10]);
        @(negedge clk);
        start = 1'b0;
        repeat (5) @(negedge clk);
        rst = 1'b0; start = 1'b1; funct3 = 3'b000; A = 32'd5; B = 32'd6; rd_in = 5'd3;
        @(negedge clk);
        chk("midcalc_rst_busy",   32'(busy),   32'd0);
        chk("midcalc_rst_done",   32'(done),   32'd0);
        chk("midcalc_rst_result", result,      32'd0);
        chk("midcalc_rst_rd_out", 32'(rd_out), 32'd0);
        @(negedge clk);
        rst = 1'b1; start = 1'b0;
        sb.delete();
        chk("start_in_reset_ignored", 32'(busy), 32'd0);
        no_done("no_done_after_reset", 40);

        // Flush and start together: flush wins.
        funct3 = 3'b000; A = 32'd9; B = 32'd9; rd_in = 5'd7;
        start = 1'b1; flush = 1'b1;
        @(negedge clk);
        start = 1'b0; flush = 1'b0;
        chk("flush_beats_start", 32'(busy), 32'd0);
        no_done("no_done_flush_start", 40);

        $display("%0d/%0d checks passed", passes, checks);
        $finish;
    end

endmodule
